next_line_prefetcher: RTL
=========================

Name: next_line_prefetcher

Overview:
- Responder side of the cache controller's prefetch handshake.
- Triggered by the controller's prefetch_start (asserted during a demand-miss read). Computes the next sequential cacheline address, fetches that line over its own port into the physical-memory arbiter, and buffers it.
- Offers the line via prefetch_ready / pf_cache_way until the controller consumes it in its prefetch state.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- LINE_BITS, 256, cacheline width in bits.
- OFFSET_BITS, 5, log2 of line size in bytes.
- PAGE_BITS, 12, log2 of page size; used only under PF_PAGE_BOUND_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- prefetch_start  in  1  controller is servicing a demand miss; level, may stay high many cycles
- miss_address  in  ADDR_WIDTH  demand-miss byte address, valid while prefetch_start=1
- lru_way  in  1  controller's current replacement way for the prefetch index
- pf_taken  in  1  controller is in its prefetch state and writes the buffered line this cycle (driven by controller index_sel)
- prefetch_ready  out  1  buffered line valid and offered
- pf_cache_way  out  1  way the controller writes the line into
- pf_address  out  ADDR_WIDTH  line-aligned address of the buffered line; tag and index are taken from it
- pf_line  out  LINE_BITS  buffered line data
- pf_pmem_read  out  1  read request to the arbiter
- pf_pmem_address  out  ADDR_WIDTH  request address
- pf_pmem_rdata  in  LINE_BITS  returned line
- pf_pmem_resp  in  1  one-cycle read completion

Behaviour:
- Reset values: every output is 0; state = IDLE; pf_line and pf_address are cleared.
- IDLE:
  - On a rising edge of prefetch_start (prefetch_start=1 and the registered copy of it = 0), compute next = {miss_address[ADDR_WIDTH-1:OFFSET_BITS] + 1, OFFSET_BITS'b0}.
  - If the increment wraps to 0 (miss line = all-ones), stay in IDLE and drop the request.
  - Otherwise latch next into pf_address and go to REQ.
  - A level-high prefetch_start after the rising edge never re-triggers.
- REQ:
  - pf_pmem_read=1 and pf_pmem_address=pf_address, held stable until pf_pmem_resp.
  - On the pf_pmem_resp cycle, latch pf_pmem_rdata into pf_line and go to OFFER.
  - Latency from trigger to the first pf_pmem_read is 1 cycle.
  - A new prefetch_start rising edge during REQ is ignored; no queueing.
- OFFER:
  - prefetch_ready=1, registered.
  - pf_cache_way = lru_way, sampled and frozen on the cycle of entry to OFFER.
  - pf_line and pf_address are held stable.
  - When pf_taken=1, prefetch_ready falls on the next edge and state returns to IDLE. The controller therefore sees ready for exactly the checkHit→prefetch transition and never re-enters its prefetch state for the same line.
  - A prefetch_start rising edge during OFFER is ignored.
  - If pf_taken=1 and a prefetch_start rising edge occur in the same cycle, return to IDLE. No new prefetch is launched for that edge.
- pf_taken while not in OFFER is ignored.
- pf_pmem_resp outside REQ is ignored.
- Reset mid-REQ: the request is abandoned and pf_pmem_read falls on the next cycle. The arbiter must discard any late response.
- Address arithmetic is unsigned and modulo 2^(ADDR_WIDTH-OFFSET_BITS); the wrap is detected by the carry-out.
- One line is outstanding at most; the buffer holds exactly one line.

Optional Feature:
- Macro: PF_PAGE_BOUND_EN.
- Defined: a trigger whose next line lies in a different page (next[ADDR_WIDTH-1:PAGE_BITS] != miss_address[ADDR_WIDTH-1:PAGE_BITS]) is dropped and the block stays in IDLE.
- Undefined: page crossings prefetch normally; only the all-ones wrap is suppressed.

Test Plan:
- Reset, then hold all inputs at 0 for 10 cycles → all outputs stay 0 and pf_pmem_read is never asserted.
- prefetch_start rises with miss_address=0x0000_1044 and is held 8 cycles; arbiter responds after 5 cycles with rdata=0xA5…A5 → exactly one request to 0x0000_1060, pf_line=0xA5…A5, prefetch_ready=1.
- In OFFER with lru_way=1 (sampled), lru_way changes to 0 → pf_cache_way stays 1; pf_taken pulses 1 cycle → prefetch_ready=0 on the next cycle, state IDLE.
- Second prefetch_start rising edge (addr 0x2000) while in REQ and again while in OFFER → both ignored; pf_address remains 0x0000_1060.
- miss_address=0xFFFF_FFE4 → no request issued, prefetch_ready stays 0. With PF_PAGE_BOUND_EN defined, miss_address=0x0000_0FE0 → no request; without the macro → request to 0x0000_1000.
- rst asserted 2 cycles into REQ → pf_pmem_read=0 next cycle; a subsequent pf_pmem_resp is ignored and prefetch_ready stays 0.

Source files
------------

// File: rtl/next_line_prefetcher.sv
// next_line_prefetcher: fetches and buffers the line after a demand miss; PF_PAGE_BOUND_EN drops page-crossing prefetches
module next_line_prefetcher #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_BITS   = 256,
  parameter int OFFSET_BITS = 5,
  parameter int PAGE_BITS   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prefetch_start,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic                  lru_way,
  input  logic                  pf_taken,
  output logic                  prefetch_ready,
  output logic                  pf_cache_way,
  output logic [ADDR_WIDTH-1:0] pf_address,
  output logic [LINE_BITS-1:0]  pf_line,
  output logic                  pf_pmem_read,
  output logic [ADDR_WIDTH-1:0] pf_pmem_address,
  input  logic [LINE_BITS-1:0]  pf_pmem_rdata,
  input  logic                  pf_pmem_resp
);
`ifdef PF_PAGE_BOUND_EN
  localparam bit PAGE_EN = 1'b1;
`else
  localparam bit PAGE_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, REQ, OFFER} state_t;
  state_t state;
  logic start_q, rise, carry, page_cross, drop, unused_offset;
  logic [ADDR_WIDTH-OFFSET_BITS-1:0] next_tag;
  logic [ADDR_WIDTH-1:0] next_addr;
  assign rise = prefetch_start & ~start_q;
  assign {carry, next_tag} = {1'b0, miss_address[ADDR_WIDTH-1:OFFSET_BITS]} + 1'b1;
  assign next_addr = {next_tag, {OFFSET_BITS{1'b0}}};
  assign page_cross = next_addr[ADDR_WIDTH-1:PAGE_BITS] != miss_address[ADDR_WIDTH-1:PAGE_BITS];
  assign drop = carry | (PAGE_EN & page_cross);
  assign unused_offset = ^miss_address[OFFSET_BITS-1:0];
  assign pf_pmem_address = pf_address;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      start_q <= 1'b0;
      pf_address <= '0;
      pf_line <= '0;
      prefetch_ready <= 1'b0;
      pf_cache_way <= 1'b0;
      pf_pmem_read <= 1'b0;
    end else begin
      start_q <= prefetch_start;
      case (state)
        IDLE: if (rise && !drop) begin
          pf_address <= next_addr;
          pf_pmem_read <= 1'b1;
          state <= REQ;
        end
        REQ: if (pf_pmem_resp) begin
          pf_line <= pf_pmem_rdata;
          pf_pmem_read <= 1'b0;
          prefetch_ready <= 1'b1;
          pf_cache_way <= lru_way;
          state <= OFFER;
        end
        OFFER: if (pf_taken) begin
          prefetch_ready <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
